// File: rtl/axi_tag_recorder_pkg.sv
// Shared types and default sizing for the PCIe tag recorder on the AXI slave TX path.
package axi_tag_recorder_pkg;

  typedef enum logic {
    KIND_WR = 1'b0,
    KIND_RD = 1'b1
  } tag_kind_t;

  localparam int TAG_WIDTH_DEFAULT          = 8;
  localparam int ID_WIDTH_DEFAULT           = 4;
  localparam int NUM_TAGS_DEFAULT           = 32;
  localparam int MAX_WR_OUTSTANDING_DEFAULT = 16;
  localparam int MAX_RD_OUTSTANDING_DEFAULT = 16;

  typedef struct packed {
    logic [ID_WIDTH_DEFAULT-1:0] id;
    tag_kind_t                   kind;
  } tag_entry_t;

endpackage

// File: rtl/axi_tag_recorder_if.sv
// Allocation, completion lookup and response signals between requester logic and the tag recorder.
interface axi_tag_recorder_if #(
  parameter int TAG_WIDTH = 8,
  parameter int ID_WIDTH  = 4,
  parameter int CNT_WIDTH = 6
);
  logic                 alloc_valid;
  logic                 alloc_kind;
  logic [ID_WIDTH-1:0]  alloc_id;
  logic                 alloc_ready;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic                 cpl_valid;
  logic [TAG_WIDTH-1:0] cpl_tag;
  logic                 cpl_last;
  logic                 rsp_valid;
  logic [ID_WIDTH-1:0]  rsp_id;
  logic                 rsp_kind;
  logic                 rsp_err;
  logic [CNT_WIDTH-1:0] wr_outstanding;
  logic [CNT_WIDTH-1:0] rd_outstanding;

  modport master (
    output alloc_valid, alloc_kind, alloc_id, cpl_valid, cpl_tag, cpl_last,
    input  alloc_ready, alloc_tag, rsp_valid, rsp_id, rsp_kind, rsp_err,
           wr_outstanding, rd_outstanding
  );

  modport slave (
    input  alloc_valid, alloc_kind, alloc_id, cpl_valid, cpl_tag, cpl_last,
    output alloc_ready, alloc_tag, rsp_valid, rsp_id, rsp_kind, rsp_err,
           wr_outstanding, rd_outstanding
  );
endinterface

// File: rtl/axi_tag_recorder_tag_free_finder.sv
// Lowest-index free tag priority encoder over the in-use vector.
module axi_tag_recorder_tag_free_finder #(
  parameter int NUM_TAGS = 32,
  parameter int IDX_W    = 5
) (
  input  logic [NUM_TAGS-1:0] in_use,
  output logic [IDX_W-1:0]    free_idx,
  output logic                any_free
);

  // Scan from the top down so the last hit wins, leaving the lowest free index.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!in_use[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_tag_recorder.sv
// PCIe tag allocator: grants free tags to AXI AW/AR requests, records {id, kind}, returns them on completion.
module axi_tag_recorder
  import axi_tag_recorder_pkg::*;
#(
  parameter int TAG_WIDTH          = TAG_WIDTH_DEFAULT,
  parameter int NUM_TAGS           = NUM_TAGS_DEFAULT,
  parameter int ID_WIDTH           = ID_WIDTH_DEFAULT,
  parameter int MAX_WR_OUTSTANDING = MAX_WR_OUTSTANDING_DEFAULT,
  parameter int MAX_RD_OUTSTANDING = MAX_RD_OUTSTANDING_DEFAULT
) (
  input logic              ACLK,
  input logic              ARESETn,
  axi_tag_recorder_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_TAGS);
  localparam int CNT_W = $clog2(NUM_TAGS + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    tag_kind_t           kind;
  } entry_t;

  logic [NUM_TAGS-1:0] in_use;
  entry_t              entries [NUM_TAGS];
  logic [CNT_W-1:0]    wr_cnt;
  logic [CNT_W-1:0]    rd_cnt;

  logic [IDX_W-1:0]    free_idx;
  logic                any_free;
  logic [IDX_W-1:0]    cpl_idx;
  entry_t              cpl_entry;
  logic                below_limit;
  logic                alloc_fire;
  logic                cpl_in_range;
  logic                cpl_hit;
  logic                free_fire;
  logic                wr_inc, wr_dec, rd_inc, rd_dec;

  axi_tag_recorder_tag_free_finder #(
    .NUM_TAGS (NUM_TAGS),
    .IDX_W    (IDX_W)
  ) u_free_finder (
    .in_use   (in_use),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  assign below_limit = (bus.alloc_kind == KIND_RD) ? (rd_cnt < CNT_W'(MAX_RD_OUTSTANDING))
                                                   : (wr_cnt < CNT_W'(MAX_WR_OUTSTANDING));
  assign bus.alloc_ready = any_free && below_limit;
  assign bus.alloc_tag   = TAG_WIDTH'(free_idx);
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

  assign cpl_idx      = bus.cpl_tag[IDX_W-1:0];
  assign cpl_in_range = 32'(bus.cpl_tag) < 32'(NUM_TAGS);
  assign cpl_entry    = entries[cpl_idx];
  assign cpl_hit      = bus.cpl_valid && cpl_in_range && in_use[cpl_idx];
  assign free_fire    = cpl_hit && bus.cpl_last;

  assign wr_inc = alloc_fire && (bus.alloc_kind == KIND_WR);
  assign rd_inc = alloc_fire && (bus.alloc_kind == KIND_RD);
  assign wr_dec = free_fire && (cpl_entry.kind == KIND_WR);
  assign rd_dec = free_fire && (cpl_entry.kind == KIND_RD);

  // Allocated tag is always free and freed tag always in use, so the two writes never collide.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      in_use <= '0;
    end else begin
      if (alloc_fire) in_use[free_idx] <= 1'b1;
      if (free_fire)  in_use[cpl_idx]  <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (alloc_fire) entries[free_idx] <= '{id: bus.alloc_id, kind: tag_kind_t'(bus.alloc_kind)};
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      case ({wr_inc, wr_dec})
        2'b10:   wr_cnt <= wr_cnt + CNT_W'(1);
        2'b01:   wr_cnt <= wr_cnt - CNT_W'(1);
        default: wr_cnt <= wr_cnt;
      endcase
      case ({rd_inc, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + CNT_W'(1);
        2'b01:   rd_cnt <= rd_cnt - CNT_W'(1);
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_kind  <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= bus.cpl_valid;
      bus.rsp_id    <= cpl_hit ? cpl_entry.id : '0;
      bus.rsp_kind  <= cpl_hit ? cpl_entry.kind : 1'b0;
      bus.rsp_err   <= bus.cpl_valid && !cpl_hit;
    end
  end

  assign bus.wr_outstanding = wr_cnt;
  assign bus.rd_outstanding = rd_cnt;

endmodule

// File: tb/tb_axi_tag_recorder.sv
// Scoreboard bench for axi_tag_recorder: directed scenarios plus random traffic against a tag-table model.
module tb_axi_tag_recorder;

  localparam int NT     = 32;
  localparam int MAX_WR = 32;
  localparam int MAX_RD = 2;

  logic clk;
  logic rst_n;

  axi_tag_recorder_if #(.TAG_WIDTH(8), .ID_WIDTH(4), .CNT_WIDTH(6)) bus ();

  axi_tag_recorder #(
    .TAG_WIDTH          (8),
    .NUM_TAGS           (NT),
    .ID_WIDTH           (4),
    .MAX_WR_OUTSTANDING (MAX_WR),
    .MAX_RD_OUTSTANDING (MAX_RD)
  ) dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int err;
    int id;
    int kind;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;

  // Model of the tag table: which tags are held, and what they hold.
  bit   m_used [NT];
  int   m_id   [NT];
  int   m_kind [NT];
  int   m_wr   = 0;
  int   m_rd   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NT; i++) if (!m_used[i]) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) m_used[i] = 1'b0;
    m_wr = 0;
    m_rd = 0;
    exp_q.delete();
  endfunction

  // One clock cycle starting and ending at a falling edge.
  task automatic cycle(input bit av, input bit ak, input int aid,
                       input bit cv, input int ct, input bit cl);
    int   lo;
    bit   exp_ready;
    bit   hit;
    exp_t e;
    bus.alloc_valid = av;
    bus.alloc_kind  = ak;
    bus.alloc_id    = 4'(aid);
    bus.cpl_valid   = cv;
    bus.cpl_tag     = 8'(ct);
    bus.cpl_last    = cl;
    #1;
    lo        = lowest_free();
    exp_ready = (lo >= 0) && (ak ? (m_rd < MAX_RD) : (m_wr < MAX_WR));
    check("wr_outstanding", int'(bus.wr_outstanding), m_wr);
    check("rd_outstanding", int'(bus.rd_outstanding), m_rd);
    if (av) begin
      check("alloc_ready", int'(bus.alloc_ready), int'(exp_ready));
      if (exp_ready) check("alloc_tag", int'(bus.alloc_tag), lo);
    end
    hit = cv && (ct < NT) && m_used[ct % NT];
    if (cv) begin
      e.due  = cyc + 1;
      e.err  = hit ? 0 : 1;
      e.id   = hit ? m_id[ct % NT] : 0;
      e.kind = hit ? m_kind[ct % NT] : 0;
      exp_q.push_back(e);
    end
    if (hit && cl) begin
      m_used[ct % NT] = 1'b0;
      if (m_kind[ct % NT] == 1) m_rd--; else m_wr--;
    end
    if (av && exp_ready) begin
      m_used[lo] = 1'b1;
      m_id[lo]   = aid & 15;
      m_kind[lo] = int'(ak);
      if (ak) m_rd++; else m_wr++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int t = 0; t < NT; t++) if (m_used[t]) cycle(0, 0, 0, 1, t, 1);
    idle();
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL rsp_unexpected: got response id %0d err %0d, none expected (cycle %0d)",
                   bus.rsp_id, bus.rsp_err, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_latency", cyc, e.due);
          check("rsp_err", int'(bus.rsp_err), e.err);
          check("rsp_id", int'(bus.rsp_id), e.id);
          check("rsp_kind", int'(bus.rsp_kind), e.kind);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        checks++;
        $display("FAIL rsp_missing: got no response, expected one due at cycle %0d (cycle %0d)",
                 exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_kind  = 1'b0;
    bus.alloc_id    = '0;
    bus.cpl_valid   = 1'b0;
    bus.cpl_tag     = '0;
    bus.cpl_last    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", int'(bus.rsp_valid), 0);
    check("reset_rsp_id", int'(bus.rsp_id), 0);
    check("reset_rsp_kind", int'(bus.rsp_kind), 0);
    check("reset_rsp_err", int'(bus.rsp_err), 0);
    check("reset_wr_cnt", int'(bus.wr_outstanding), 0);
    check("reset_rd_cnt", int'(bus.rd_outstanding), 0);
    rst_n = 1'b1;
    #1;
    check("reset_alloc_ready", int'(bus.alloc_ready), 1);
    check("reset_alloc_tag", int'(bus.alloc_tag), 0);
    @(negedge clk);

    // Fill all 32 tags with writes; the last one saturates both free tags and MAX_WR.
    for (int i = 0; i < NT; i++) cycle(1, 0, $urandom_range(15), 0, 0, 0);
    cycle(1, 0, 3, 0, 0, 0);
    check("full_wr_cnt", int'(bus.wr_outstanding), 32);
    check("full_ready", int'(bus.alloc_ready), 0);

    // Free tag 3 while requesting: blocked now, granted tag 3 next cycle.
    cycle(1, 0, 9, 1, 3, 1);
    cycle(1, 0, 9, 0, 0, 0);
    check("refill_tag3_used", int'(m_used[3]), 1);
    drain();

    // Read limit of 2: third read stalls, a write still goes through, freeing read tag 0 unblocks.
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 2, 0, 0, 0);
    cycle(1, 1, 3, 0, 0, 0);
    cycle(1, 0, 4, 0, 0, 0);
    cycle(1, 1, 3, 1, 0, 1);
    cycle(1, 1, 3, 0, 0, 0);
    drain();

    // Multi-completion on tag 5 holding read ID 0xA.
    for (int i = 0; i < 5; i++) cycle(1, 0, i, 0, 0, 0);
    cycle(1, 1, 10, 0, 0, 0);
    cycle(1, 0, 1, 1, 5, 0);
    cycle(0, 0, 0, 1, 5, 1);
    cycle(1, 0, 2, 0, 0, 0);
    drain();

    // Completions for an unallocated tag and an out-of-range tag.
    cycle(0, 0, 0, 1, 7, 1);
    cycle(0, 0, 0, 1, 40, 1);
    idle();

    // Lookup of the tag being allocated on the same edge sees it as unallocated.
    cycle(1, 0, 6, 1, 0, 1);
    drain();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int ct;
      ct = $urandom_range(63);
      if ($urandom_range(99) < 70) begin
        int start;
        start = $urandom_range(NT - 1);
        for (int k = 0; k < NT; k++) begin
          if (m_used[(start + k) % NT]) begin
            ct = (start + k) % NT;
            break;
          end
        end
      end
      cycle($urandom_range(99) < 60, $urandom_range(1), $urandom_range(15),
            $urandom_range(99) < 55, ct, $urandom_range(1));
    end
    drain();

    // Asynchronous reset mid-cycle with 10 tags outstanding.
    for (int i = 0; i < 10; i++) cycle(1, 0, i, 0, 0, 0);
    check("pre_reset_wr_cnt", int'(bus.wr_outstanding), 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_wr_cnt", int'(bus.wr_outstanding), 0);
    check("async_reset_rd_cnt", int'(bus.rd_outstanding), 0);
    check("async_reset_tag", int'(bus.alloc_tag), 0);
    check("async_reset_rsp_valid", int'(bus.rsp_valid), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 5, 1, 4, 1);
    idle();
    idle();

    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL rsp_drain: got %0d responses still outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
